// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data-cache controller: FSM state encodings,
// address-split widths and line width. Used by dcache_ctrl and dcache_array.
package dcache_ctrl_pkg;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_LINE_WORDS = 4;
    localparam int OFFSET_BITS    = 2;

    // Word-select width inside a line (LINE_WORDS is a power of 2, >= 2)
    function automatic int word_bits_f(input int line_words);
        return $clog2(line_words);
    endfunction

    // Tag width is whatever remains of the 32-bit byte address
    function automatic int tag_bits_f(input int index_bits, input int line_words);
        return 32 - OFFSET_BITS - $clog2(line_words) - index_bits;
    endfunction

    function automatic int line_bits_f(input int line_words);
        return 32 * line_words;
    endfunction

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CHK   = 2'd1;
    localparam state_t ST_RMISS = 2'd2;
    localparam state_t ST_WMEM  = 2'd3;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache.
// Combinational read, synchronous write; a byte-merge port for store hits
// and a full-line fill port for read misses (never active together).
import dcache_ctrl_pkg::*;

module dcache_array #(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int WORD_BITS  = word_bits_f(DEF_LINE_WORDS),
    parameter int TAG_BITS   = tag_bits_f(DEF_INDEX_BITS, DEF_LINE_WORDS),
    parameter int LINE_BITS  = line_bits_f(DEF_LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  merge_en,
    input  logic [WORD_BITS-1:0]  merge_word,
    input  logic [3:0]            merge_web,
    input  logic [31:0]           merge_data,
    input  logic                  fill_en,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [LINE_BITS-1:0]  fill_line
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];

    assign rd_valid = valid_q[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];

    // Valid bits are the only storage that must be cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data writes: whole-line fill, or byte-merge of one word on a store hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[idx]  <= fill_tag;
            data_mem[idx] <= fill_line;
        end else if (merge_en) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (merge_word == WORD_BITS'(w) && merge_web[b]) begin
                        data_mem[idx][w*32 + b*8 +: 8] <= merge_data[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Optional macro DCACHE_STATS_EN adds saturating hit/miss counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for core_req; request latched on acceptance
// CHK      | tag compare; load hit completes, store merges on hit
// RMISS    | line read outstanding on D_*, fill + complete on D_ack
// WMEM     | word write-through outstanding on D_*, complete on D_ack
import dcache_ctrl_pkg::*;

module dcache_ctrl #(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_req,
    input  logic                   core_write,
    input  logic [31:0]            core_addr,
    input  logic [3:0]             core_web,
    input  logic [31:0]            core_in,
    output logic [31:0]            core_out,
    output logic                   core_wait,
    output logic                   p_ready,
    output logic                   D_req,
    output logic                   D_write,
    output logic [31:0]            D_addr,
    output logic [3:0]             D_web,
    output logic [31:0]            D_in,
    input  logic [32*LINE_WORDS-1:0] D_out,
    input  logic                   D_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]            stat_hits,
    output logic [31:0]            stat_misses
`endif
);

    localparam int WORD_BITS = word_bits_f(LINE_WORDS);
    localparam int TAG_BITS  = tag_bits_f(INDEX_BITS, LINE_WORDS);
    localparam int LINE_BITS = line_bits_f(LINE_WORDS);
    localparam int IDX_LSB   = OFFSET_BITS + WORD_BITS;
    localparam int TAG_LSB   = IDX_LSB + INDEX_BITS;

    state_t state;

    logic [31:0] req_addr;
    logic        req_write;
    logic [3:0]  req_web;
    logic [31:0] req_data;

    logic [WORD_BITS-1:0]  req_word;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;

    logic                 arr_valid;
    logic [TAG_BITS-1:0]  arr_tag;
    logic [LINE_BITS-1:0] arr_line;
    logic                 hit;
    logic                 merge_en;
    logic                 fill_en;
    logic [31:0]          hit_word;
    logic [31:0]          fill_word;

    assign req_word = req_addr[OFFSET_BITS +: WORD_BITS];
    assign req_idx  = req_addr[IDX_LSB +: INDEX_BITS];
    assign req_tag  = req_addr[31:TAG_LSB];

    assign hit      = arr_valid && (arr_tag == req_tag);
    assign merge_en = (state == ST_CHK) && req_write && hit;
    assign fill_en  = (state == ST_RMISS) && D_ack;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS),
        .LINE_BITS  (LINE_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .idx        (req_idx),
        .rd_valid   (arr_valid),
        .rd_tag     (arr_tag),
        .rd_line    (arr_line),
        .merge_en   (merge_en),
        .merge_word (req_word),
        .merge_web  (req_web),
        .merge_data (req_data),
        .fill_en    (fill_en),
        .fill_tag   (req_tag),
        .fill_line  (D_out)
    );

    // Select the requested word from the cached line and from the incoming fill line
    always_comb begin
        hit_word  = '0;
        fill_word = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (req_word == WORD_BITS'(w)) begin
                hit_word  = arr_line[w*32 +: 32];
                fill_word = D_out[w*32 +: 32];
            end
        end
    end

    // Main FSM; p_ready and core_out are registered so completion lands in IDLE.
    // A request arriving in the p_ready cycle is not accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_write <= 1'b0;
            req_web   <= '0;
            req_data  <= '0;
            p_ready   <= 1'b0;
            core_out  <= '0;
        end else begin
            p_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_req && !p_ready) begin
                        req_addr  <= core_addr;
                        req_write <= core_write;
                        req_web   <= core_web;
                        req_data  <= core_in;
                        state     <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (req_write) begin
                        state <= ST_WMEM;
                    end else if (hit) begin
                        core_out <= hit_word;
                        p_ready  <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        state <= ST_RMISS;
                    end
                end
                ST_RMISS: begin
                    if (D_ack) begin
                        core_out <= fill_word;
                        p_ready  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_WMEM: begin
                    if (D_ack) begin
                        p_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stall and memory-side outputs decode straight from state, so reset drops them at once
    always_comb begin
        core_wait = 1'b0;
        D_req     = 1'b0;
        D_write   = 1'b0;
        D_addr    = '0;
        D_web     = '0;
        D_in      = '0;
        if (!rst) begin
            case (state)
                ST_IDLE:  core_wait = core_req && !p_ready;
                ST_CHK:   core_wait = 1'b1;
                ST_RMISS: begin
                    core_wait = 1'b1;
                    D_req     = 1'b1;
                    D_addr    = {req_tag, req_idx, {IDX_LSB{1'b0}}};
                end
                ST_WMEM: begin
                    core_wait = 1'b1;
                    D_req     = 1'b1;
                    D_write   = 1'b1;
                    D_addr    = req_addr;
                    D_web     = req_web;
                    D_in      = req_data;
                end
                default: core_wait = 1'b0;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating hit/miss counters, updated on the tag-compare cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == ST_CHK) begin
            if (hit) begin
                if (stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
            end else begin
                if (stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule
